// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates,
// line/frame pulses and a frame counter, advanced by a pixel strobe.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CW         = 10,
  parameter int FW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

  // One extra bit so region bounds equal to 2^CW still compare correctly
  localparam logic [CW:0] H_ACT = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SB  = (CW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [CW:0] H_SE  = (CW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_ACT = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SB  = (CW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [CW:0] V_SE  = (CW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic H_POL = 1'(H_SYNC_POL);
  localparam logic V_POL = 1'(V_SYNC_POL);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic [FW-1:0] fc_q, fc_d;

  logic [CW:0] hx, vx;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode the upcoming position so outputs line up with the counters
  always_comb begin
    hx   = {1'b0, h_d};
    vx   = {1'b0, v_d};
    de_d = (hx < H_ACT) && (vx < V_ACT);
    hs_d = ((hx >= H_SB) && (hx < H_SE)) ? H_POL : ~H_POL;
    vs_d = ((vx >= V_SB) && (vx < V_SE)) ? V_POL : ~V_POL;
    ls_d = pix_en && (h_d == '0);
    fs_d = ls_d && (v_d == '0);
    fc_d = fs_d ? fc_q + 1'b1 : fc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q  <= H_MAX;
      v_q  <= V_MAX;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '1;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign display_en  = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
